// File: rtl/shift_frame_pkg.sv
// Shared constants and helpers for the shift_frame_capture block.
package shift_frame_pkg;

  localparam int DEFAULT_WIDTH = 128;

  // Values for the LSB_FIRST parameter.
  localparam bit SHIFT_MSB_IN = 1'b0;
  localparam bit SHIFT_LSB_IN = 1'b1;

  // Width of the bit counter.
  function automatic int cnt_width(input int width);
    int cw;
    cw = $clog2(width);
    return (cw < 1) ? 1 : cw;
  endfunction

endpackage

// File: rtl/shift_frame_capture_core.sv
// Direction-parametrised shift register with frame bit counter.
module shift_core
  import shift_frame_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit LSB_FIRST = SHIFT_MSB_IN,
  localparam int CW       = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] outs,
  output logic [CW-1:0]    bit_cnt,
  output logic             frame_done,
  output logic [WIDTH-1:0] next_sr
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    next_sr = outs;
    if (LSB_FIRST == SHIFT_LSB_IN) next_sr = {in, outs[WIDTH-1:1]};
    else                           next_sr = {outs[WIDTH-2:0], in};
  end

  // Strobe on the edge that accepts the last bit of a frame.
  assign frame_done = en && !clr && (bit_cnt == LAST);

  // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outs    <= '0;
      bit_cnt <= '0;
    end else if (clr) begin
      outs    <= '0;
      bit_cnt <= '0;
    end else if (en) begin
      outs    <= next_sr;
      bit_cnt <= frame_done ? '0 : bit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/shift_frame_capture.sv
// Serial-in/parallel-out capture with a one-deep valid/ready frame buffer.
module shift_frame_capture
  import shift_frame_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit LSB_FIRST = SHIFT_MSB_IN,
  localparam int CW       = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] outs,
  output logic [CW-1:0]    bit_cnt,
  output logic [WIDTH-1:0] frame_data,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic             overflow
);

  logic             frame_done;
  logic [WIDTH-1:0] next_sr;
  logic             consume;
  logic             accept;
  logic             drop;

  shift_core #(
    .WIDTH    (WIDTH),
    .LSB_FIRST(LSB_FIRST)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .en        (en),
    .clr       (clr),
    .outs      (outs),
    .bit_cnt   (bit_cnt),
    .frame_done(frame_done),
    .next_sr   (next_sr)
  );

  // A buffer being drained this cycle can take the new frame without loss.
  assign consume = frame_valid && frame_ready;
  assign accept  = frame_done && (!frame_valid || frame_ready);
  assign drop    = frame_done && frame_valid && !frame_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_data  <= '0;
      frame_valid <= 1'b0;
    end else if (accept) begin
      frame_data  <= next_sr;
      frame_valid <= 1'b1;
    end else if (consume) begin
      frame_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     overflow <= 1'b0;
    else if (clr)   overflow <= 1'b0;
    else if (drop)  overflow <= 1'b1;
  end

endmodule

// File: tb/tb_shift_frame_capture.sv
// Scoreboard bench: three instances (8-bit MSB-in, 8-bit LSB-in, 128-bit MSB-in) on shared stimulus.
module tb_shift_frame_capture;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic s_in, s_en, s_clr, frame_ready;

  logic [7:0]   outs0, fdata0, outs1, fdata1;
  logic [127:0] outs2, fdata2;
  logic [2:0]   cnt0, cnt1;
  logic [6:0]   cnt2;
  logic         fv0, fv1, fv2, ov0, ov1, ov2;

  logic [127:0] d_outs[N], d_fdata[N];
  logic [6:0]   d_cnt[N];
  logic         d_fv[N], d_ov[N];

  int total = 0;
  int bad   = 0;

  // Reference model: bit history since last clear, buffer occupancy, expected frames.
  bit           hist[N][$];
  logic [127:0] exp_q[N][$];
  int           m_cnt[N];
  bit           m_valid[N];
  bit           m_ov[N];
  int           pops[N];

  always #5 clk = ~clk;

  shift_frame_capture #(.WIDTH(8), .LSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in(s_in), .en(s_en), .clr(s_clr),
    .outs(outs0), .bit_cnt(cnt0), .frame_data(fdata0), .frame_valid(fv0),
    .frame_ready(frame_ready), .overflow(ov0));

  shift_frame_capture #(.WIDTH(8), .LSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in(s_in), .en(s_en), .clr(s_clr),
    .outs(outs1), .bit_cnt(cnt1), .frame_data(fdata1), .frame_valid(fv1),
    .frame_ready(frame_ready), .overflow(ov1));

  shift_frame_capture #(.WIDTH(128), .LSB_FIRST(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .in(s_in), .en(s_en), .clr(s_clr),
    .outs(outs2), .bit_cnt(cnt2), .frame_data(fdata2), .frame_valid(fv2),
    .frame_ready(frame_ready), .overflow(ov2));

  assign d_outs[0] = 128'(outs0);  assign d_fdata[0] = 128'(fdata0);  assign d_cnt[0] = 7'(cnt0);
  assign d_outs[1] = 128'(outs1);  assign d_fdata[1] = 128'(fdata1);  assign d_cnt[1] = 7'(cnt1);
  assign d_outs[2] = outs2;        assign d_fdata[2] = fdata2;         assign d_cnt[2] = cnt2;
  assign d_fv[0] = fv0;  assign d_fv[1] = fv1;  assign d_fv[2] = fv2;
  assign d_ov[0] = ov0;  assign d_ov[1] = ov1;  assign d_ov[2] = ov2;

  function automatic int w_of(input int i);
    return (i == 2) ? 128 : 8;
  endfunction

  function automatic bit lsb_of(input int i);
    return (i == 1);
  endfunction

  // Live register content: the bit received 'age' edges ago sits 'age' places from the entry end.
  function automatic logic [127:0] word_of(input int i);
    logic [127:0] w;
    int sz;
    w  = '0;
    sz = hist[i].size();
    for (int j = 0; j < sz; j++) begin
      int age;
      age = sz - 1 - j;
      if (hist[i][j]) begin
        if (lsb_of(i)) w[w_of(i) - 1 - age] = 1'b1;
        else           w[age] = 1'b1;
      end
    end
    return w;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      hist[i].delete();
      exp_q[i].delete();
      m_cnt[i]   = 0;
      m_valid[i] = 1'b0;
      m_ov[i]    = 1'b0;
    end
  endtask

  task automatic model_step(input bit b_in, input bit b_en, input bit b_clr, input bit b_rdy);
    for (int i = 0; i < N; i++) begin
      bit consume;
      consume = m_valid[i] && b_rdy;
      if (b_clr) begin
        hist[i].delete();
        m_cnt[i] = 0;
        m_ov[i]  = 1'b0;
        if (consume) m_valid[i] = 1'b0;
      end else if (b_en) begin
        hist[i].push_back(b_in);
        if (hist[i].size() > w_of(i)) void'(hist[i].pop_front());
        m_cnt[i] = m_cnt[i] + 1;
        if (m_cnt[i] == w_of(i)) begin
          m_cnt[i] = 0;
          if (!m_valid[i] || consume) begin
            exp_q[i].push_back(word_of(i));
            m_valid[i] = 1'b1;
          end else begin
            m_ov[i] = 1'b1;
          end
        end else if (consume) begin
          m_valid[i] = 1'b0;
        end
      end else if (consume) begin
        m_valid[i] = 1'b0;
      end
    end
  endtask

  // Entered and left at posedge+1; the model advances right after the edge.
  task automatic cycle(input bit b_in, input bit b_en, input bit b_clr, input bit b_rdy);
    s_in = b_in;  s_en = b_en;  s_clr = b_clr;  frame_ready = b_rdy;
    @(posedge clk);
    model_step(b_in, b_en, b_clr, b_rdy);
    #1;
  endtask

  // Monitor: compares live state every cycle and pops the scoreboard on each handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        check($sformatf("outs%0d", i), d_outs[i], word_of(i));
        check($sformatf("bit_cnt%0d", i), 128'(d_cnt[i]), 128'(m_cnt[i]));
        check($sformatf("frame_valid%0d", i), 128'(d_fv[i]), 128'(m_valid[i]));
        check($sformatf("overflow%0d", i), 128'(d_ov[i]), 128'(m_ov[i]));
        if (d_fv[i] && frame_ready) begin
          if (exp_q[i].size() == 0) begin
            check($sformatf("sb_underflow%0d", i), 128'(exp_q[i].size()), 128'd1);
          end else begin
            check($sformatf("frame_data%0d", i), d_fdata[i], exp_q[i].pop_front());
            pops[i]++;
          end
        end
      end
    end
  end

  initial begin
    bit seq[8];
    seq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < N; i++) pops[i] = 0;

    rst_n = 1'b0;
    s_in = 1'b0;  s_en = 1'b0;  s_clr = 1'b0;  frame_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Load data, then assert reset between edges.
    for (int k = 0; k < 10; k++) cycle(1'(k % 3 != 2), 1'b1, 1'b0, 1'b0);
    s_en = 1'b0;  frame_ready = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("rst_outs%0d", i), d_outs[i], '0);
      check($sformatf("rst_cnt%0d", i), 128'(d_cnt[i]), '0);
      check($sformatf("rst_fdata%0d", i), d_fdata[i], '0);
      check($sformatf("rst_fv%0d", i), 128'(d_fv[i]), '0);
      check($sformatf("rst_ov%0d", i), 128'(d_ov[i]), '0);
    end
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (5) cycle(1'b1, 1'b0, 1'b0, 1'b0);

    // Directed frame in both directions.
    for (int k = 0; k < 8; k++) cycle(seq[k], 1'b1, 1'b0, 1'b0);
    check("msb_frame", 128'(fdata0), 128'h B2);
    check("lsb_frame", 128'(fdata1), 128'h 4D);
    check("msb_valid", 128'(fv0), 128'd1);
    check("msb_cnt_wrap", 128'(cnt0), 128'd0);

    // Second frame with no consumer is dropped.
    for (int k = 0; k < 8; k++) cycle(1'($urandom), 1'b1, 1'b0, 1'b0);
    check("ovf_msb", 128'(ov0), 128'd1);
    check("ovf_lsb", 128'(ov1), 128'd1);
    check("ovf_kept", 128'(fdata0), 128'h B2);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("clr_ovf", 128'(ov0), 128'd0);
    check("clr_keeps_valid", 128'(fv0), 128'd1);

    // Clear a partial frame, then capture fresh bits.
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) cycle(1'($urandom), 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) cycle(1'($urandom), 1'b1, 1'b0, 1'b1);

    // Enable toggling every other cycle.
    for (int k = 0; k < 40; k++) cycle(1'($urandom), 1'(k % 2), 1'b0, 1'($urandom));

    // Three full-rate 128-bit frames with a consumer always ready.
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    pops[2] = 0;
    repeat (384) cycle(1'($urandom), 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("b2b_frames", 128'(pops[2]), 128'd3);
    check("b2b_ovf", 128'(ov2), 128'd0);

    // Random traffic.
    repeat (400) cycle(1'($urandom), 1'($urandom_range(0, 3) != 0),
                       1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 2) != 0));

    repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < N; i++)
      check($sformatf("sb_drained%0d", i), 128'(exp_q[i].size()), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_frame_capture.md
# shift_frame_capture

Parametrised serial-in/parallel-out capture register: successor to the fixed 128-bit enable-gated shift register. Adds configurable width and shift direction, a bit counter, synchronous clear, and a one-deep frame buffer. The buffer presents each completed WIDTH-bit word on a valid/ready handshake, with sticky overflow detection. It sits between a serial bit source and any parallel consumer in the datapath.

## Interface
- `WIDTH`, default 128: shift/frame width in bits; legal range ≥ 2.
- `LSB_FIRST`, default 0: selects shift direction.
  - 0: new bit enters bit 0 and contents move toward the MSB (legacy behaviour).
  - 1: new bit enters bit WIDTH-1 and contents move toward bit 0.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `in`  in  1: serial data bit, sampled when `en`=1.
- `en`  in  1: shift enable; one bit accepted per cycle while high.
- `clr`  in  1: synchronous clear of the shift register, bit counter and `overflow`.
- `outs`  out  WIDTH: live shift-register contents.
- `bit_cnt`  out  CW: bits accepted in the current frame, 0..WIDTH-1, where CW = $clog2(WIDTH).
- `frame_data`  out  WIDTH: last completed frame.
- `frame_valid`  out  1: `frame_data` holds an unconsumed frame.
- `frame_ready`  in  1: consumer accepts `frame_data` in any cycle where `frame_valid`=1.
- `overflow`  out  1: sticky; a completed frame was dropped.

## Operation
- **Reset** (`rst_n`=0, asynchronous): `outs`, `bit_cnt`, `frame_data`, `frame_valid` and `overflow` all go to 0.
- **Priority** per cycle: `clr` > `en`. Nothing changes when `clr`=0 and `en`=0.
- **Shift** (`en`=1, `clr`=0):
  - LSB_FIRST=0: shift register ← {sr[WIDTH-2:0], in}.
  - LSB_FIRST=1: shift register ← {in, sr[WIDTH-1:1]}.
  - `bit_cnt` increments, wrapping from WIDTH-1 to 0.
- **Frame complete**: `en`=1 with `bit_cnt`=WIDTH-1. Let "next shift value" be the shift-register value written at this edge.
  - If the buffer is empty, or is being consumed this cycle (`frame_valid` & `frame_ready`): `frame_data` ← next shift value; `frame_valid` ← 1.
  - Otherwise (`frame_valid`=1, `frame_ready`=0): the new frame is dropped, `frame_data` is kept, and `overflow` ← 1.
- **Consume**: `frame_valid` & `frame_ready` with no completion in the same cycle → `frame_valid` ← 0. `frame_data` holds its last value.
- **Clear** (`clr`=1):
  - Shift register, `bit_cnt` and `overflow` ← 0.
  - `frame_valid` and `frame_data` are unaffected; a handshake in the same cycle still consumes.
  - A partial frame is discarded.
- The shift register is never cleared on frame completion; it keeps shifting continuously.

## Timing
- `outs` reflects a bit sampled at edge N from edge N onward, i.e. 1-cycle latency.
- `frame_valid` rises at the same edge that samples the WIDTH-th bit of a frame.
- The handshake takes effect at the edge where `frame_valid` & `frame_ready` are both sampled high.
- Back-to-back frames at full rate (`en` held high) incur no loss while the consumer keeps `frame_ready`=1.
- All outputs are registered; there is no combinational path from inputs to outputs.
- When reset deasserts mid-stream, the frame restarts at `bit_cnt`=0.

## Structure
- Package `shift_frame_pkg` holds:
  - `DEFAULT_WIDTH` = 128
  - the `LSB_FIRST` direction constants `SHIFT_MSB_IN`/`SHIFT_LSB_IN`
  - a function computing CW, with minimum 1
- Sub-module `shift_core` contains the direction-parametrised shift register and `bit_cnt`, and emits a `frame_done` strobe plus the next shift value.
- The top level adds the frame buffer, handshake and overflow logic.

## Test plan
- **Reset and idle**: WIDTH=8; `rst_n` pulsed low mid-cycle → all outputs 0 immediately. Then `en`=0 for 5 cycles → outputs stay 0.
- **MSB-first capture**: WIDTH=8, LSB_FIRST=0; shift 1,0,1,1,0,0,1,0 → `frame_data`=8'hB2 and `frame_valid`=1 at the 8th edge; `bit_cnt`=0.
- **LSB-first capture**: WIDTH=8, LSB_FIRST=1; same bit sequence → `frame_data`=8'h4D.
- **Overflow**: WIDTH=8, `frame_ready`=0; shift 16 bits → first frame retained, `overflow`=1 at the 16th edge. Then `clr`=1 → `overflow`=0 while `frame_valid` stays 1.
- **Back-to-back frames**: `frame_ready`=1, `en` continuous for 3 frames of WIDTH=128 → 3 valid frames, correct data each time, `overflow`=0.
- **Clear mid-frame and gated enable**: `clr` after 5 bits, then 8 fresh bits → frame contains only the fresh bits. Toggling `en` (0 every other cycle) shows the shift register and `bit_cnt` hold whenever `en`=0.
